// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared widths, select/state encodings and slot payload for the forwarding/hazard controller.
package fwd_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned FWD_SEL_W      = 2;
    localparam int unsigned HZ_W           = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_SEL_REG = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_EX  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_MEM = 2'b10;
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_WB  = 2'b11;

    typedef enum logic [HZ_W-1:0] {
        HZ_RUN      = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      is_load;
    } slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// Per-operand forwarding priority encoder: EX > MEM > WB (optional) > regfile.
module fwd_hazard_ctrl_fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_WB = 1'b1
) (
    input  logic                      i_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_addr,
    input  logic                      i_ex_act,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_mem_act,
    input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
    input  logic                      i_wb_act,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
    output logic [FWD_SEL_W-1:0]      o_sel_c
);

    // Youngest matching producer wins; unused or x0 sources always read the regfile.
    always_comb begin
        o_sel_c = FWD_SEL_REG;
        if (i_used && (i_addr != '0)) begin
            if (i_ex_act && (i_ex_rd == i_addr)) begin
                o_sel_c = FWD_SEL_EX;
            end else if (i_mem_act && (i_mem_rd == i_addr)) begin
                o_sel_c = FWD_SEL_MEM;
            end else if (FWD_WB && i_wb_act && (i_wb_rd == i_addr)) begin
                o_sel_c = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ID-stage forwarding select and load-use / load-wait stall control.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter bit          FWD_WB = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    input  logic                      ex_flush,
    input  logic                      pipe_freeze,
    input  logic                      mem_load_done,
    output logic [FWD_SEL_W-1:0]      fwd1_sel,
    output logic [FWD_SEL_W-1:0]      fwd2_sel,
    output logic                      stall_id,
    output logic                      stall_mem,
    output logic                      ex_bubble,
    output logic [HZ_W-1:0]           hz_state,
    output logic [CNT_W-1:0]          stall_cnt
);

    slot_t                     r_ex;
    slot_t                     r_mem;
    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic                      r_wb_we;
    hz_state_e                 r_state;
    hz_state_e                 w_state_nxt;
    logic [CNT_W-1:0]          r_stall_cnt;

    logic  w_ex_act;
    logic  w_mem_act;
    logic  w_wb_act;
    logic  w_lu_hit;
    logic  w_lu_stall;
    logic  w_stall_mem;
    slot_t w_id_slot;

    // Slot qualification, hazard detection and stall outputs.
    always_comb begin
        w_ex_act    = r_ex.valid && r_ex.we && (r_ex.rd != '0);
        w_mem_act   = r_mem.valid && r_mem.we && (r_mem.rd != '0);
        w_wb_act    = r_wb_valid && r_wb_we && (r_wb_rd != '0);
        w_lu_hit    = id_valid && w_ex_act && r_ex.is_load &&
                      ((id_rs1_used && (id_rs1_addr == r_ex.rd)) ||
                       (id_rs2_used && (id_rs2_addr == r_ex.rd)));
        // A flush kills the consumer, so no load-use stall is needed.
        w_lu_stall  = w_lu_hit && !ex_flush;
        w_stall_mem = r_mem.valid && r_mem.is_load && !mem_load_done;
        stall_mem   = w_stall_mem;
        stall_id    = w_stall_mem || w_lu_stall;
        ex_bubble   = w_lu_stall && !w_stall_mem;
        hz_state    = r_state;
        stall_cnt   = r_stall_cnt;
    end

    // Payload the ID instruction would carry into EX on an advancing cycle.
    always_comb begin
        w_id_slot         = '0;
        w_id_slot.valid   = id_valid && !ex_flush && !stall_id;
        w_id_slot.rd      = id_rd_addr;
        w_id_slot.we      = id_rd_we;
        w_id_slot.is_load = id_is_load;
    end

    // EX/MEM/WB slot pipeline: freeze holds all, load wait holds EX/MEM and drains WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_we    <= 1'b0;
        end else if (!pipe_freeze) begin
            if (w_stall_mem) begin
                r_wb_valid <= 1'b0;
            end else begin
                r_wb_valid <= r_mem.valid;
                r_wb_rd    <= r_mem.rd;
                r_wb_we    <= r_mem.we;
                r_mem      <= r_ex;
                r_ex       <= w_id_slot;
            end
        end
    end

    // Hazard FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: freeze holds, load wait dominates, otherwise track load-use bubbles.
    always_comb begin
        w_state_nxt = r_state;
        if (!pipe_freeze) begin
            if (w_stall_mem) begin
                w_state_nxt = HZ_MEM_WAIT;
            end else if (w_lu_stall) begin
                w_state_nxt = HZ_LOAD_USE;
            end else begin
                w_state_nxt = HZ_RUN;
            end
        end
    end

    // Stall performance counter; wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_id && !pipe_freeze) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    fwd_hazard_ctrl_fwd_match #(.FWD_WB(FWD_WB)) u_fwd1 (
        .i_used    (id_rs1_used),
        .i_addr    (id_rs1_addr),
        .i_ex_act  (w_ex_act),
        .i_ex_rd   (r_ex.rd),
        .i_mem_act (w_mem_act),
        .i_mem_rd  (r_mem.rd),
        .i_wb_act  (w_wb_act),
        .i_wb_rd   (r_wb_rd),
        .o_sel_c   (fwd1_sel)
    );

    fwd_hazard_ctrl_fwd_match #(.FWD_WB(FWD_WB)) u_fwd2 (
        .i_used    (id_rs2_used),
        .i_addr    (id_rs2_addr),
        .i_ex_act  (w_ex_act),
        .i_ex_rd   (r_ex.rd),
        .i_mem_act (w_mem_act),
        .i_mem_rd  (r_mem.rd),
        .i_wb_act  (w_wb_act),
        .i_wb_rd   (r_wb_rd),
        .o_sel_c   (fwd2_sel)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_is_load;
    logic        ex_flush;
    logic        pipe_freeze;
    logic        mem_load_done;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic        stall_id;
    logic        stall_mem;
    logic        ex_bubble;
    logic [1:0]  hz_state;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_ctrl #(.FWD_WB(1'b1), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rd_addr    (id_rd_addr),
        .id_rd_we      (id_rd_we),
        .id_is_load    (id_is_load),
        .ex_flush      (ex_flush),
        .pipe_freeze   (pipe_freeze),
        .mem_load_done (mem_load_done),
        .fwd1_sel      (fwd1_sel),
        .fwd2_sel      (fwd2_sel),
        .stall_id      (stall_id),
        .stall_mem     (stall_mem),
        .ex_bubble     (ex_bubble),
        .hz_state      (hz_state),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        id_valid    = v;
        id_rs1_addr = a1;
        id_rs2_addr = a2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd_addr  = rd;
        id_rd_we    = we;
        id_is_load  = ld;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        id_nop();
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1;
        ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        mem_load_done = 1'b1;
        id_nop();
        #3;
        check_eq("rst_fwd1", 32'(fwd1_sel), 32'd0);
        check_eq("rst_stall_id", 32'(stall_id), 32'd0);
        check_eq("rst_hz", 32'(hz_state), 32'd0);
        check_eq("rst_cnt", stall_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // EX forwarding on rs1 only
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        id_set(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        check_eq("ex_fwd1", 32'(fwd1_sel), 32'd1);
        check_eq("ex_fwd2", 32'(fwd2_sel), 32'd0);
        check_eq("ex_stall_id", 32'(stall_id), 32'd0);
        step();

        // EX beats MEM for x7; x6 sits in WB
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        step();
        id_set(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check_eq("prio_fwd2_ex", 32'(fwd2_sel), 32'd1);
        check_eq("wb_fwd1", 32'(fwd1_sel), 32'd3);
        step();
        // x7 now in MEM (beats WB copy); rs2 x8 in EX but unused
        id_set(1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check_eq("mem_fwd1", 32'(fwd1_sel), 32'd2);
        check_eq("unused_fwd2", 32'(fwd2_sel), 32'd0);
        drain();
        id_set(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check_eq("drained_fwd1", 32'(fwd1_sel), 32'd0);
        check_eq("drained_fwd2", 32'(fwd2_sel), 32'd0);

        // Load-use on x9
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        step();
        id_set(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        #1;
        check_eq("lu_stall_id", 32'(stall_id), 32'd1);
        check_eq("lu_bubble", 32'(ex_bubble), 32'd1);
        check_eq("lu_stall_mem", 32'(stall_mem), 32'd0);
        step();
        check_eq("lu_hz", 32'(hz_state), 32'd1);
        check_eq("lu_cnt", stall_cnt, 32'd1);
        check_eq("lu_fwd1_mem", 32'(fwd1_sel), 32'd2);
        check_eq("lu_release", 32'(stall_id), 32'd0);
        check_eq("lu_bubble_off", 32'(ex_bubble), 32'd0);
        step();
        check_eq("lu_back_run", 32'(hz_state), 32'd0);
        check_eq("lu_fwd1_wb", 32'(fwd1_sel), 32'd3);
        drain();

        // Multi-cycle load wait on x9
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        step();
        id_nop();
        step();
        mem_load_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("mw_stall_mem", 32'(stall_mem), 32'd1);
            check_eq("mw_stall_id", 32'(stall_id), 32'd1);
            step();
            check_eq("mw_hz", 32'(hz_state), 32'd2);
        end
        check_eq("mw_cnt", stall_cnt, 32'd4);
        mem_load_done = 1'b1;
        #1;
        check_eq("mw_done_stall", 32'(stall_mem), 32'd0);
        step();
        check_eq("mw_run", 32'(hz_state), 32'd0);
        check_eq("mw_cnt_hold", stall_cnt, 32'd4);
        drain();

        // x0 destination never forwards
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("x0_fwd1", 32'(fwd1_sel), 32'd0);
            check_eq("x0_fwd2", 32'(fwd2_sel), 32'd0);
            step();
        end
        drain();

        // Flush wins over load-use
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1);
        step();
        id_set(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        ex_flush = 1'b1;
        #1;
        check_eq("fl_stall_id", 32'(stall_id), 32'd0);
        check_eq("fl_bubble", 32'(ex_bubble), 32'd0);
        step();
        ex_flush = 1'b0;
        id_set(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check_eq("fl_hz", 32'(hz_state), 32'd0);
        check_eq("fl_cnt", stall_cnt, 32'd4);
        check_eq("fl_fwd1_mem", 32'(fwd1_sel), 32'd2);
        check_eq("fl_killed_ex", 32'(fwd2_sel), 32'd0);
        drain();

        // Freeze holds state and counter despite a load-use hazard
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1);
        step();
        id_set(1'b1, 5'd0, 5'd13, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0);
        pipe_freeze = 1'b1;
        step();
        check_eq("fz_hz", 32'(hz_state), 32'd0);
        check_eq("fz_cnt", stall_cnt, 32'd4);
        check_eq("fz_fwd2_ex", 32'(fwd2_sel), 32'd1);
        pipe_freeze = 1'b0;
        step();
        check_eq("fz_lu_hz", 32'(hz_state), 32'd1);
        check_eq("fz_lu_cnt", stall_cnt, 32'd5);
        drain();

        // Async reset in the middle of a load wait
        id_set(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        step();
        id_nop();
        step();
        mem_load_done = 1'b0;
        step();
        check_eq("pre_rst_hz", 32'(hz_state), 32'd2);
        check_eq("pre_rst_cnt", stall_cnt, 32'd6);
        id_set(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_hz", 32'(hz_state), 32'd0);
        check_eq("arst_stall_id", 32'(stall_id), 32'd0);
        check_eq("arst_stall_mem", 32'(stall_mem), 32'd0);
        check_eq("arst_bubble", 32'(ex_bubble), 32'd0);
        check_eq("arst_fwd1", 32'(fwd1_sel), 32'd0);
        check_eq("arst_fwd2", 32'(fwd2_sel), 32'd0);
        check_eq("arst_cnt", stall_cnt, 32'd0);
        step();
        rst = 1'b0;
        mem_load_done = 1'b1;
        step();
        check_eq("post_rst_hz", 32'(hz_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
